// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
// Optional feature macro: RR_ARB_EN (round-robin arbitration instead of MEM priority).
package regfile_wb_scheduler_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  // x0 is hard-wired zero, so it can never be reported as busy.
  function automatic logic reg_busy(input logic [NREG-1:0] vec, input logic [AW-1:0] idx);
    return (idx != '0) & vec[idx];
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Busy scoreboard: one bit per architectural register, set on reservation,
// cleared when the register file commits; a same-edge set beats the clear.
module wb_scoreboard
  import regfile_wb_scheduler_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_rd,
  output logic [NREG-1:0] busy,
  output logic            hazard
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            set_en;

  always_comb begin
    hazard = rsv_valid & (reg_busy(busy_q, rs1) |
                          reg_busy(busy_q, rs2) |
                          reg_busy(busy_q, rsv_rd));
  end

  assign set_en = rsv_valid & ~hazard & (rsv_rd != '0);

  // Clear first so that a reservation on the same edge leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (set_en) begin
      busy_d[rsv_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between ALU and load results and tracks
// in-flight destinations. Define RR_ARB_EN for round-robin; default is MEM priority.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            hazard,
  output logic [NREG-1:0] busy,
  output logic            rf_rw,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_din
);

  logic            alu_grant;
  logic            mem_grant;
  logic            rf_rw_q,  rf_rw_d;
  logic [AW-1:0]   rf_rd_q,  rf_rd_d;
  logic [XLEN-1:0] rf_din_q, rf_din_d;

`ifdef RR_ARB_EN
  req_e last_q, last_d;

  // On contention the requester that did not win last time is granted.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (rst) begin
      if (alu_valid && mem_valid) begin
        if (last_q == REQ_MEM) begin
          alu_grant = 1'b1;
        end else begin
          mem_grant = 1'b1;
        end
      end else begin
        alu_grant = alu_valid;
        mem_grant = mem_valid;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (alu_grant) begin
      last_d = REQ_ALU;
    end else if (mem_grant) begin
      last_d = REQ_MEM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= REQ_MEM;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    mem_grant = rst & mem_valid;
    alu_grant = rst & alu_valid & ~mem_valid;
  end
`endif

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  // An accepted x0 write still updates address/data but never enables the write.
  always_comb begin
    rf_rw_d  = 1'b0;
    rf_rd_d  = rf_rd_q;
    rf_din_d = rf_din_q;
    if (alu_grant) begin
      rf_rw_d  = (alu_rd != '0);
      rf_rd_d  = alu_rd;
      rf_din_d = alu_data;
    end else if (mem_grant) begin
      rf_rw_d  = (mem_rd != '0);
      rf_rd_d  = mem_rd;
      rf_din_d = mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_rw_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_din_q <= '0;
    end else begin
      rf_rw_q  <= rf_rw_d;
      rf_rd_q  <= rf_rd_d;
      rf_din_q <= rf_din_d;
    end
  end

  assign rf_rw  = rf_rw_q;
  assign rf_rd  = rf_rd_q;
  assign rf_din = rf_din_q;

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rsv_valid (rsv_valid),
    .rsv_rd    (rsv_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .clr_en    (rf_rw_q),
    .clr_rd    (rf_rd_q),
    .busy      (busy),
    .hazard    (hazard)
  );

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 32×32 register file: shares its single write port (rw/rd/din) between the ALU and memory-load result producers with a valid/ready handshake. It also tracks pending destinations in a busy scoreboard so decode stalls on read-after-write and write-after-write hazards. Sits between the execute/memory stages and the register file; register-file read ports stay driven directly by decode.

## Interface
- XLEN, 32, data width
- NREG, 32, register count (x0 hard-wired zero)
- AW, 5, register index width (log2 NREG)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result pending
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  AW  ALU destination
- alu_data  in  XLEN  ALU result
- mem_valid  in  1  load result pending
- mem_ready  out  1  load result accepted this cycle
- mem_rd  in  AW  load destination
- mem_data  in  XLEN  load result
- rsv_valid  in  1  decode issuing an instruction that writes rsv_rd
- rsv_rd  in  AW  destination being reserved
- rs1, rs2  in  AW  decode source registers
- hazard  out  1  decode must stall this cycle
- busy  out  NREG  scoreboard, bit r = write to xr in flight
- rf_rw  out  1  register-file write enable
- rf_rd  out  AW  register-file write address
- rf_din  out  XLEN  register-file write data

## Operation
- Handshake: a transfer occurs in cycle N when valid & ready are both high at the rising edge ending N. ready is combinational from both valids and the arbitration pointer; at most one of alu_ready/mem_ready is high per cycle. A producer holds valid, rd and data stable until accepted.
- Arbitration: single requester is granted immediately. On contention, grant goes to the requester not granted last (pointer `last`). `last` updates on every grant.
- Write issue: an accepted transfer loads rf_rw=1, rf_rd=rd, rf_din=data on the same edge. Otherwise rf_rw=0 next cycle, with rf_rd/rf_din held.
- x0: a transfer with rd=0 is accepted normally but loads rf_rw=0.
- Scoreboard set: busy[rsv_rd] is set on the edge where rsv_valid & ~hazard & rsv_rd≠0.
- Scoreboard clear: busy[rf_rd] is cleared on the edge where rf_rw=1, i.e. the edge the register file commits the data.
- Set and clear of the same register on one edge: set wins, because a new producer is in flight.
- hazard = rsv_valid & (busy[rs1] | busy[rs2] | busy[rsv_rd]), where any term indexing x0 reads 0. The check is combinational.
- A result arriving for a register whose busy bit is clear is still written; the scoreboard does not filter transfers.

## Timing
- Reset (rst=0, async): rf_rw=0, rf_rd=0, rf_din=0, busy=0, last=MEM (ALU wins first contention). While rst=0, alu_ready=mem_ready=0 and hazard=0.
- Latency: handshake in cycle N, rf_rw high during N+1, register file commits at the end of N+1. The busy bit is clear from N+2, so a dependent instruction reading in N+2 sees the new value.
- Throughput: one write per cycle sustained. Back-to-back contention alternates ALU/MEM.
- Reset mid-operation: an un-issued rf write is dropped and all reservations are lost. Producers re-present after reset.

## Configuration
- RR_ARB_EN defined: round-robin as above.
- RR_ARB_EN undefined: fixed priority, MEM always beats ALU. The `last` register is removed, and the ALU may starve under continuous loads.

## Structure
- Shared package: XLEN/NREG/AW constants and a requester enum (REQ_ALU, REQ_MEM) used for `last`.
- One sub-module: `wb_scoreboard` (busy vector, set/clear priority, hazard compare). The arbiter and write register stay in the top module.

## Test plan
- Reset: assert rst=0 mid-run with busy[5]=1 -> busy=0, rf_rw=0, readys 0 immediately (async); after release, ALU wins the first contention.
- Single write: alu_valid, rd=2, data=50 in cycle N -> alu_ready=1 in N; rf_rw=1, rf_rd=2, rf_din=50 in N+1; rf_rw=0 in N+2.
- Contention: both valid (ALU rd=3/75, MEM rd=4/99) held 2 cycles -> ALU accepted first, MEM second. With RR_ARB_EN undefined, MEM is accepted first.
- Hazard: reserve rd=7; next cycle rsv_valid with rs1=7 -> hazard=1 until the cycle after rf_rw=1/rf_rd=7, then hazard=0.
- x0: MEM write rd=0, data=123 -> mem_ready=1, rf_rw stays 0. Reserve rsv_rd=0 -> busy unchanged, hazard=0.
- Set/clear collision: rf_rw=1 rf_rd=9 while reserving rsv_rd=9 on the same edge -> busy[9]=1 afterwards.
